// File: rtl/excess3_pkg.sv
// Shared constants and state encoding for the Excess-3 to BCD sequencer.
package excess3_pkg;

    localparam int         DIGIT_W     = 4;
    localparam logic [3:0] E3_OFFSET   = 4'd3;
    localparam logic [3:0] E3_MIN      = 4'h3;
    localparam logic [3:0] E3_MAX      = 4'hC;
    localparam logic [3:0] BCD_INVALID = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

endpackage

// File: rtl/e3_digit_conv.sv
// Combinational single-digit Excess-3 to BCD converter with out-of-range flag.
module e3_digit_conv
    import excess3_pkg::*;
(
    input  logic [DIGIT_W-1:0] code,
    output logic [DIGIT_W-1:0] bcd,
    output logic               invalid
);

    assign bcd     = code - E3_OFFSET;
    assign invalid = (code < E3_MIN) || (code > E3_MAX);

endmodule

// File: rtl/excess3_bcd_seq.sv
// Multi-digit Excess-3 to BCD sequencer, one digit per clock, LSD first.
// Build option E3_DIGIT_CHECK_EN: flag invalid codes, write 4'hF and raise out_err.
//
// state | meaning
// IDLE  | waiting for an input word (in_ready=1)
// CONV  | converting digit idx each clock
// DONE  | result held on out_data until out_ready
module excess3_bcd_seq
    import excess3_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DIGIT_W*NDIGITS-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DIGIT_W*NDIGITS-1:0] out_data,
    output logic                       out_err,
    output logic                       busy
);

    localparam int              IDXW     = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIGITS - 1);

    state_t                     state_q, state_d;
    logic [IDXW-1:0]            idx_q, idx_d;
    logic [DIGIT_W*NDIGITS-1:0] src_q, src_d;
    logic [DIGIT_W*NDIGITS-1:0] result_q, result_d;
    logic                       err_q, err_d;

    logic [DIGIT_W-1:0] cur_code;
    logic [DIGIT_W-1:0] conv_bcd;
    logic               conv_invalid;
    logic               digit_bad;
    logic [DIGIT_W-1:0] digit_out;

    always_comb begin
        cur_code = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx_q == IDXW'(i)) cur_code = src_q[DIGIT_W*i +: DIGIT_W];
        end
    end

    e3_digit_conv u_conv (
        .code    (cur_code),
        .bcd     (conv_bcd),
        .invalid (conv_invalid)
    );

`ifdef E3_DIGIT_CHECK_EN
    assign digit_bad = conv_invalid;
`else
    logic unused_conv_invalid;
    assign unused_conv_invalid = conv_invalid;
    assign digit_bad           = 1'b0;
`endif

    assign digit_out = digit_bad ? BCD_INVALID : conv_bcd;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        src_d    = src_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    src_d    = in_data;
                    result_d = '0;
                    err_d    = 1'b0;
                    idx_d    = '0;
                    state_d  = CONV;
                end
            end
            CONV: begin
                for (int i = 0; i < NDIGITS; i++) begin
                    if (idx_q == IDXW'(i)) result_d[DIGIT_W*i +: DIGIT_W] = digit_out;
                end
                err_d = err_q | digit_bad;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            src_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            src_q    <= src_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = result_q;
    // err_q is only ever set with checking enabled; expose it only while the word is presented
    assign out_err   = err_q && (state_q == DONE);

endmodule

// File: tb/tb_excess3_bcd_seq.sv
// Directed self-checking bench for excess3_bcd_seq (NDIGITS=4).
module tb_excess3_bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    excess3_bcd_seq #(.NDIGITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] word);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk("send_ready", {63'd0, in_ready}, 64'd1);
        in_data  = word;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
    endtask

    int  lat;
    logic seen;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {48'd0, out_data}, 64'h0);
        chk("rst_out_err", {63'd0, out_err}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);

        // basic conversion and latency
        send(16'h48C3);
        chk("basic_busy", {63'd0, busy}, 64'd1);
        chk("basic_in_ready", {63'd0, in_ready}, 64'd0);
        wait_valid(lat);
        chk("basic_latency", 64'(lat), 64'd4);
        chk("basic_data", {48'd0, out_data}, 64'h1590);
        chk("basic_err", {63'd0, out_err}, 64'd0);
        step();
        chk("basic_valid_one_cycle", {63'd0, out_valid}, 64'd0);
        chk("basic_back_idle", {63'd0, in_ready}, 64'd1);

        // invalid digits
        send(16'h4203);
        wait_valid(lat);
        chk("inv_latency", 64'(lat), 64'd4);
`ifdef E3_DIGIT_CHECK_EN
        chk("inv_data", {48'd0, out_data}, 64'h1FF0);
        chk("inv_err", {63'd0, out_err}, 64'd1);
`else
        chk("inv_data", {48'd0, out_data}, 64'h1FD0);
        chk("inv_err", {63'd0, out_err}, 64'd0);
`endif
        step();

        // backpressure
        out_ready = 1'b0;
        send(16'h48C3);
        wait_valid(lat);
        chk("bp_latency", 64'(lat), 64'd4);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_data", {48'd0, out_data}, 64'h1590);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
        chk("bp_release_valid", {63'd0, out_valid}, 64'd0);

        // new word offered while busy must wait for IDLE
        send(16'h3333);
        in_data  = 16'hCCCC;
        in_valid = 1'b1;
        wait_valid(lat);
        chk("busy_latency", 64'(lat), 64'd4);
        chk("busy_data_first", {48'd0, out_data}, 64'h0000);
        chk("busy_in_ready", {63'd0, in_ready}, 64'd0);
        step();
        chk("busy_idle_again", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        chk("busy_second_accept", {63'd0, busy}, 64'd1);
        wait_valid(lat);
        chk("busy_second_latency", 64'(lat), 64'd4);
        chk("busy_data_second", {48'd0, out_data}, 64'h9999);
        step();

        // reset mid-conversion
        send(16'h48C3);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_data", {48'd0, out_data}, 64'h0);
        chk("mid_rst_err", {63'd0, out_err}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chk("mid_rst_no_valid", {63'd0, seen}, 64'd0);
        send(16'h5A73);
        wait_valid(lat);
        chk("post_rst_latency", 64'(lat), 64'd4);
        chk("post_rst_data", {48'd0, out_data}, 64'h2740);
        step();

        // range boundaries
        send(16'hC3C3);
        wait_valid(lat);
        chk("bound_a_latency", 64'(lat), 64'd4);
        chk("bound_a_data", {48'd0, out_data}, 64'h9090);
        chk("bound_a_err", {63'd0, out_err}, 64'd0);
        step();
        send(16'h3C3C);
        wait_valid(lat);
        chk("bound_b_latency", 64'(lat), 64'd4);
        chk("bound_b_data", {48'd0, out_data}, 64'h0909);
        chk("bound_b_err", {63'd0, out_err}, 64'd0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
